pwm_monitor: RTL and testbench

- Decoder for the per-transducer PWM drive: samples one PWM_OUT waveform against the shared TIME_CNT.
- Reconstructs LEFT/RIGHT/OVER and duty, the inverse of the pwm_preconditioner → pwm_gen encoding, once per ultrasound period.
- Sits beside the transducer output array as a self-test/feedback tap; results feed the CPU-readable status path.

---
 rtl/pwm_pkg.sv | 27 ++
 rtl/edge_capture.sv | 87 ++++++++
 rtl/pwm_monitor.sv | 149 ++++++++++++++
 tb/tb_pwm_monitor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the PWM monitor: FSM states, result record and edge-count helper.
package pwm_pkg;

    localparam int PWM_WIDTH = 13;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_MEASURE = 2'd2,
        ST_PUBLISH = 2'd3
    } pwm_state_e;

    typedef struct packed {
        logic [PWM_WIDTH-1:0] left;
        logic [PWM_WIDTH-1:0] right;
        logic                 over;
        logic [PWM_WIDTH-1:0] duty;
        logic                 stuck;
        logic                 glitch;
    } pwm_result_t;

    // Edge counts only need to distinguish none / one / more than one.
    function automatic logic [1:0] sat_inc2(input logic [1:0] cnt);
        return (cnt >= 2'd2) ? 2'd2 : cnt + 2'd1;
    endfunction

endpackage

// File: rtl/edge_capture.sv
// Per-period edge bookkeeping on the sampled PWM: first rise/fall time, saturating counts, high count.
// start_i opens a new period with the current sample included; registered, no backpressure.
module edge_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sample_i,
    input  logic [WIDTH-1:0] t_adj_i,
    input  logic             start_i,
    input  logic             acc_i,
    output logic [WIDTH-1:0] rise_t_o,
    output logic [WIDTH-1:0] fall_t_o,
    output logic [1:0]       rise_cnt_o,
    output logic [1:0]       fall_cnt_o,
    output logic [WIDTH-1:0] high_cnt_o
);

    logic             prev_q;
    logic [WIDTH-1:0] rise_t_q, rise_t_d;
    logic [WIDTH-1:0] fall_t_q, fall_t_d;
    logic [1:0]       rise_cnt_q, rise_cnt_d;
    logic [1:0]       fall_cnt_q, fall_cnt_d;
    logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
    logic             rise, fall;

    assign rise = ~prev_q &  sample_i;
    assign fall =  prev_q & ~sample_i;

    always_comb begin
        rise_t_d   = rise_t_q;
        fall_t_d   = fall_t_q;
        rise_cnt_d = rise_cnt_q;
        fall_cnt_d = fall_cnt_q;
        high_cnt_d = high_cnt_q;
        if (start_i) begin
            rise_t_d   = '0;
            fall_t_d   = '0;
            rise_cnt_d = 2'd0;
            fall_cnt_d = 2'd0;
            high_cnt_d = '0;
        end
        // The boundary sample is the first sample of the period being opened.
        if (start_i || acc_i) begin
            if (rise) begin
                if (rise_cnt_d == 2'd0) begin
                    rise_t_d = t_adj_i;
                end
                rise_cnt_d = sat_inc2(rise_cnt_d);
            end
            if (fall) begin
                if (fall_cnt_d == 2'd0) begin
                    fall_t_d = t_adj_i;
                end
                fall_cnt_d = sat_inc2(fall_cnt_d);
            end
            high_cnt_d = high_cnt_d + {{(WIDTH-1){1'b0}}, sample_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q     <= 1'b0;
            rise_t_q   <= '0;
            fall_t_q   <= '0;
            rise_cnt_q <= 2'd0;
            fall_cnt_q <= 2'd0;
            high_cnt_q <= '0;
        end else begin
            prev_q     <= sample_i;
            rise_t_q   <= rise_t_d;
            fall_t_q   <= fall_t_d;
            rise_cnt_q <= rise_cnt_d;
            fall_cnt_q <= fall_cnt_d;
            high_cnt_q <= high_cnt_d;
        end
    end

    assign rise_t_o   = rise_t_q;
    assign fall_t_o   = fall_t_q;
    assign rise_cnt_o = rise_cnt_q;
    assign fall_cnt_o = fall_cnt_q;
    assign high_cnt_o = high_cnt_q;

endmodule

// File: rtl/pwm_monitor.sv
// Decodes one PWM drive waveform back into LEFT/RIGHT/OVER/DUTY once per period against TIME_CNT.
// Results and VALID update one clock after the period boundary; free-running tap, no backpressure.
module pwm_monitor
    import pwm_pkg::*;
#(
    parameter int WIDTH   = PWM_WIDTH,
    parameter int LATENCY = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENABLE,
    input  logic [WIDTH-1:0] TIME_CNT,
    input  logic [WIDTH-1:0] CYCLE,
    input  logic             PWM_IN,
    output logic [WIDTH-1:0] LEFT,
    output logic [WIDTH-1:0] RIGHT,
    output logic             OVER,
    output logic [WIDTH-1:0] DUTY,
    output logic             STUCK,
    output logic             GLITCH,
    output logic             VALID
);

    pwm_state_e       state_q, state_d;
    logic [WIDTH-1:0] cyc_q, cyc_d;
    logic [WIDTH-1:0] cyc_cur;
    logic [WIDTH:0]   t_sum;
    logic [WIDTH-1:0] t_adj;
    logic             boundary;
    logic             start, acc, publish;
    pwm_result_t      res_q, res_d;
    logic             valid_q;

    logic [WIDTH-1:0] rise_t, fall_t, high_cnt;
    logic [1:0]       rise_cnt, fall_cnt;

    // Before the first boundary there is no latched period, so align against the live CYCLE.
    assign cyc_cur  = (state_q == ST_MEASURE || state_q == ST_PUBLISH) ? cyc_q : CYCLE;
    assign t_sum    = {1'b0, TIME_CNT} + {1'b0, cyc_cur} - (WIDTH+1)'(LATENCY);
    assign t_adj    = WIDTH'((t_sum >= {1'b0, cyc_cur}) ? t_sum - {1'b0, cyc_cur} : t_sum);
    assign boundary = (t_adj == '0);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        start   = 1'b0;
        acc     = 1'b0;
        publish = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_SYNC;
            end
            ST_SYNC: begin
                if (boundary) begin
                    state_d = ST_MEASURE;
                    start   = 1'b1;
                    cyc_d   = CYCLE;
                end
            end
            ST_MEASURE: begin
                acc = 1'b1;
                if (boundary) begin
                    state_d = ST_PUBLISH;
                    start   = 1'b1;
                    cyc_d   = CYCLE;
                    publish = 1'b1;
                end
            end
            ST_PUBLISH: begin
                acc     = 1'b1;
                state_d = ST_MEASURE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!ENABLE) begin
            state_d = ST_IDLE;
            cyc_d   = cyc_q;
            start   = 1'b0;
            acc     = 1'b0;
            publish = 1'b0;
        end
    end

    // Accumulators still hold the closing period here; the boundary sample goes to the next one.
    always_comb begin
        res_d = res_q;
        if (publish) begin
            if (rise_cnt == 2'd0 && fall_cnt == 2'd0) begin
                res_d.left   = '0;
                res_d.right  = '0;
                res_d.over   = 1'b0;
                res_d.duty   = PWM_WIDTH'(high_cnt);
                res_d.stuck  = 1'b1;
                res_d.glitch = 1'b0;
            end else if (rise_cnt == 2'd1 && fall_cnt == 2'd1) begin
                res_d.left   = PWM_WIDTH'(rise_t);
                res_d.right  = PWM_WIDTH'(fall_t);
                res_d.over   = (rise_t > fall_t);
                res_d.duty   = PWM_WIDTH'(high_cnt);
                res_d.stuck  = 1'b0;
                res_d.glitch = 1'b0;
            end else begin
                res_d.stuck  = 1'b0;
                res_d.glitch = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            res_q   <= res_d;
            valid_q <= publish;
        end
    end

    edge_capture #(
        .WIDTH(WIDTH)
    ) u_edge_capture (
        .clk_i      (CLK),
        .rst_i      (RST),
        .sample_i   (PWM_IN),
        .t_adj_i    (t_adj),
        .start_i    (start),
        .acc_i      (acc),
        .rise_t_o   (rise_t),
        .fall_t_o   (fall_t),
        .rise_cnt_o (rise_cnt),
        .fall_cnt_o (fall_cnt),
        .high_cnt_o (high_cnt)
    );

    assign LEFT   = WIDTH'(res_q.left);
    assign RIGHT  = WIDTH'(res_q.right);
    assign OVER   = res_q.over;
    assign DUTY   = WIDTH'(res_q.duty);
    assign STUCK  = res_q.stuck;
    assign GLITCH = res_q.glitch;
    assign VALID  = valid_q;

endmodule

// File: tb/tb_pwm_monitor.sv
// Directed bench for pwm_monitor: a LATENCY=1 time counter and per-period PWM patterns.
module tb_pwm_monitor;

    localparam int W       = 13;
    localparam int K_LOW   = 0;
    localparam int K_HIGH  = 1;
    localparam int K_PULSE = 2;
    localparam int K_WRAP  = 3;
    localparam int K_TWO   = 4;

    typedef struct {
        int kind;
        int a;
        int b;
        int c;
        int d;
    } pat_t;

    logic         CLK = 1'b0;
    logic         RST;
    logic         ENABLE;
    logic [W-1:0] TIME_CNT;
    logic [W-1:0] CYCLE;
    logic         PWM_IN;
    logic [W-1:0] LEFT, RIGHT, DUTY;
    logic         OVER, STUCK, GLITCH, VALID;

    int   tests = 0;
    int   fails = 0;
    int   ta, ta_cyc, cyc_no, wraps, valid_seen, valid_ta, valid_at;
    pat_t cur, nxt;

    always #5 CLK = ~CLK;

    pwm_monitor #(
        .WIDTH   (W),
        .LATENCY (1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ENABLE   (ENABLE),
        .TIME_CNT (TIME_CNT),
        .CYCLE    (CYCLE),
        .PWM_IN   (PWM_IN),
        .LEFT     (LEFT),
        .RIGHT    (RIGHT),
        .OVER     (OVER),
        .DUTY     (DUTY),
        .STUCK    (STUCK),
        .GLITCH   (GLITCH),
        .VALID    (VALID)
    );

    function automatic pat_t mk(input int k, input int a, input int b, input int c, input int d);
        pat_t p;
        p.kind = k; p.a = a; p.b = b; p.c = c; p.d = d;
        return p;
    endfunction

    function automatic logic pwm_at(input pat_t p, input int t);
        case (p.kind)
            K_LOW:   return 1'b0;
            K_HIGH:  return 1'b1;
            K_PULSE: return (t >= p.a && t < p.b);
            K_WRAP:  return (t >= p.a || t < p.b);
            default: return (t >= p.a && t < p.b) || (t >= p.c && t < p.d);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ta is the aligned time of the sample on PWM_IN; TIME_CNT runs one count ahead of it.
    task automatic step();
        @(posedge CLK);
        #1;
        cyc_no++;
        if (VALID === 1'b1) begin
            valid_seen++;
            valid_ta = ta;
            valid_at = cyc_no;
        end
        if (ta + 1 >= ta_cyc) begin
            ta     = 0;
            ta_cyc = int'(CYCLE);
            cur    = nxt;
            wraps++;
        end else begin
            ta = ta + 1;
        end
        TIME_CNT = W'((ta + 1 >= ta_cyc) ? 0 : ta + 1);
        PWM_IN   = pwm_at(cur, ta);
    endtask

    task automatic wait_valid(input string tag);
        int seen0;
        seen0 = valid_seen;
        for (int n = 0; n < 12000 && valid_seen == seen0; n++) step();
        check({tag, ".valid_seen"}, (valid_seen != seen0), 1);
        check({tag, ".valid_at_boundary"}, valid_ta, 0);
    endtask

    task automatic wait_wrap(input string tag);
        int w0;
        w0 = wraps;
        for (int n = 0; n < 12000 && wraps == w0; n++) step();
        check({tag, ".wrapped"}, (wraps != w0), 1);
    endtask

    task automatic check_res(input string tag, input int l, input int r, input int o,
                             input int d, input int s, input int g);
        check({tag, ".left"},   LEFT,   l);
        check({tag, ".right"},  RIGHT,  r);
        check({tag, ".over"},   OVER,   o);
        check({tag, ".duty"},   DUTY,   d);
        check({tag, ".stuck"},  STUCK,  s);
        check({tag, ".glitch"}, GLITCH, g);
    endtask

    initial begin
        int at_prev, w0, v0;
        RST        = 1'b1;
        ENABLE     = 1'b0;
        CYCLE      = W'(5000);
        ta_cyc     = 5000;
        ta         = 0;
        cyc_no     = 0;
        wraps      = 0;
        valid_seen = 0;
        valid_ta   = -1;
        valid_at   = 0;
        cur        = mk(K_PULSE, 1250, 3750, 0, 0);
        nxt        = cur;
        TIME_CNT   = W'(1);
        PWM_IN     = pwm_at(cur, 0);

        repeat (3) step();
        check_res("reset", 0, 0, 0, 0, 0, 0);
        check("reset.valid", VALID, 0);

        RST    = 1'b0;
        ENABLE = 1'b1;
        wait_wrap("sync");
        nxt = mk(K_TWO, 100, 200, 300, 400);
        wait_valid("clean");
        check_res("clean", 1250, 3750, 0, 2500, 0, 0);

        nxt = mk(K_PULSE, 1250, 3750, 0, 0);
        wait_valid("two_pulse");
        check_res("two_pulse", 1250, 3750, 0, 2500, 0, 1);

        nxt = mk(K_LOW, 0, 0, 0, 0);
        wait_valid("clean2");
        check_res("clean2", 1250, 3750, 0, 2500, 0, 0);

        nxt = mk(K_WRAP, 4000, 1000, 0, 0);
        wait_valid("stuck0");
        check_res("stuck0", 0, 0, 0, 0, 1, 0);

        // First wrapped period starts high after a low period: edge at the boundary makes it a glitch.
        nxt = mk(K_WRAP, 4000, 1000, 0, 0);
        wait_valid("wrap_entry");
        check_res("wrap_entry", 0, 0, 0, 0, 0, 1);

        nxt = mk(K_HIGH, 0, 0, 0, 0);
        wait_valid("wrapped");
        check_res("wrapped", 4000, 1000, 1, 2000, 0, 0);

        nxt = mk(K_HIGH, 0, 0, 0, 0);
        wait_valid("stuck1");
        check_res("stuck1", 0, 0, 0, 5000, 1, 0);
        at_prev = valid_at;

        for (int n = 0; n < 6000 && ta != 2000; n++) step();
        CYCLE = W'(4000);
        wait_valid("cyc_old");
        check_res("cyc_old", 0, 0, 0, 5000, 1, 0);
        check("cyc_old.interval", valid_at - at_prev, 5000);
        at_prev = valid_at;

        wait_valid("cyc_new");
        check_res("cyc_new", 0, 0, 0, 4000, 1, 0);
        check("cyc_new.interval", valid_at - at_prev, 4000);

        for (int n = 0; n < 6000 && ta != 2500; n++) step();
        RST = 1'b1;
        w0  = wraps;
        #1;
        check("rst_mid.duty", DUTY, 0);
        check("rst_mid.stuck", STUCK, 0);
        check("rst_mid.valid", VALID, 0);
        step();
        step();
        RST = 1'b0;
        wait_valid("after_rst");
        check("after_rst.boundaries", wraps - w0, 2);
        check_res("after_rst", 0, 0, 0, 4000, 1, 0);

        ENABLE = 1'b0;
        nxt    = mk(K_LOW, 0, 0, 0, 0);
        v0     = valid_seen;
        repeat (9000) step();
        check("disabled.valid_count", valid_seen - v0, 0);
        check_res("disabled", 0, 0, 0, 4000, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
